// File: rtl/seg7_pkg.sv
// Shared types, active-low 7-segment codes and the BCD decode function for the scan driver.
// Leading-zero suppression in the top is enabled by SEG7_LEADING_ZERO_BLANK_EN.
package seg7_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Segment order {g,f,e,d,c,b,a}; a cleared bit lights the segment.
    localparam seg_t SEG_0    = 7'h40;
    localparam seg_t SEG_1    = 7'h79;
    localparam seg_t SEG_2    = 7'h24;
    localparam seg_t SEG_3    = 7'h30;
    localparam seg_t SEG_4    = 7'h19;
    localparam seg_t SEG_5    = 7'h12;
    localparam seg_t SEG_6    = 7'h02;
    localparam seg_t SEG_7    = 7'h78;
    localparam seg_t SEG_8    = 7'h00;
    localparam seg_t SEG_9    = 7'h10;
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

    // Codes 10..15 are not BCD and render as a dash.
    function automatic seg_t bcd_to_seg7(input bcd_t bcd);
        seg_t seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder on the muxed digit path.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t bcd_i,
    output seg_t seg_n_c_o
);

    assign seg_n_c_o = bcd_to_seg7(bcd_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver fed by a packed BCD digit bus.
// Define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic                        update,
    input  logic                        blank,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic [SEG_W-1:0]            seg_n
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]                 pre_q, pre_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]            an_q, an_d;
    seg_t                             seg_q, seg_d;

    bcd_t sel_bcd_c;
    seg_t sel_seg_c;
    logic dark_c;

    // Prescaler and digit index; each digit holds for SCAN_DIV cycles.
    always_comb begin
        pre_d = pre_q + DIV_W'(1);
        idx_d = idx_q;
        if (pre_q == DIV_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign shadow_d  = update ? digits_in : shadow_q;
    assign sel_bcd_c = shadow_q[idx_q];

    seg7_decode u_decode (
        .bcd_i     (sel_bcd_c),
        .seg_n_c_o (sel_seg_c)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero_c;

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        logic run;
        run         = 1'b1;
        lead_zero_c = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            run            = run & (shadow_q[i] == '0);
            lead_zero_c[i] = run;
        end
    end

    assign dark_c = lead_zero_c[idx_q];
`else
    assign dark_c = 1'b0;
`endif

    // Output next state from the current index and shadow contents.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (!blank && !dark_c) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = sel_seg_c;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            an_q     <= '1;
            seg_q    <= SEG_OFF;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an_n  = an_q;
    assign seg_n = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a time-based behavioural model.
// Honours SEG7_LEADING_ZERO_BLANK_EN when defined for both DUT and bench.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [4*N-1:0] digits_in = '0;
    logic           update = 1'b0;
    logic           blank = 1'b0;
    logic [N-1:0]   an_n;
    logic [6:0]     seg_n;

    int total = 0;
    int bad   = 0;

    // Model: edges seen since reset release, and the displayed digit values.
    int         m_edges;
    int         m_shadow [N];
    int         last_idx;
    logic [6:0] seg_tab [16];

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .digits_in (digits_in),
        .update    (update),
        .blank     (blank),
        .an_n      (an_n),
        .seg_n     (seg_n)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [N-1:0] a_exp, input logic [6:0] s_exp);
        total++;
        assert ({an_n, seg_n} === {a_exp, s_exp}) else begin
            bad++;
            $error("FAIL %s: an_n=%b seg_n=%h expected an_n=%b seg_n=%h", tag, an_n, seg_n, a_exp, s_exp);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        for (int i = 0; i < N; i++) m_shadow[i] = 0;
    endtask

    // One clock: drive inputs, let the edge happen, predict and compare.
    task automatic step(input logic upd, input logic blk, input logic [4*N-1:0] din, input string tag);
        int         idx;
        bit         lead;
        logic [N-1:0] a_exp;
        logic [6:0] s_exp;
        digits_in = din;
        update    = upd;
        blank     = blk;
        @(posedge clock);
        idx   = (m_edges / DIV) % N;
        a_exp = '1;
        s_exp = 7'h7F;
        lead  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx != 0) begin
            lead = 1'b1;
            for (int j = idx; j < N; j++) if (m_shadow[j] != 0) lead = 1'b0;
        end
`endif
        if (!blk && !lead) begin
            a_exp      = '1;
            a_exp[idx] = 1'b0;
            s_exp      = seg_tab[m_shadow[idx]];
        end
        last_idx = idx;
        if (upd) for (int i = 0; i < N; i++) m_shadow[i] = int'(din[4*i +: 4]);
        m_edges++;
        #1;
        check(tag, a_exp, s_exp);
    endtask

    function automatic logic [4*N-1:0] rand_digits();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) v[4*i +: 4] = 4'd0;
            else v[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        logic [4*N-1:0] cur;
        int guard;
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
        seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
        seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
        model_reset();

        // Reset held across edges, then released between edges.
        repeat (2) @(posedge clock);
        #1;
        check("reset_held", 4'b1111, 7'h7F);
        reset = 1'b0;
        step(1'b0, 1'b0, '0, "first_edge");

        cur = 16'h1234;
        step(1'b1, 1'b0, cur, "load_1234");
        repeat (20) step(1'b0, 1'b0, cur, "scan_1234");

        cur = 16'h00AF;
        step(1'b1, 1'b0, cur, "load_00af");
        repeat (16) step(1'b0, 1'b0, cur, "scan_00af");

        cur = 16'h0000;
        step(1'b1, 1'b0, cur, "load_zero");
        repeat (16) step(1'b0, 1'b0, cur, "scan_zero");

        cur = 16'h5678;
        step(1'b1, 1'b0, cur, "load_5678");
        repeat (5) step(1'b0, 1'b0, cur, "pre_blank");
        repeat (6) step(1'b0, 1'b1, cur, "blank");
        repeat (10) step(1'b0, 1'b0, cur, "post_blank");

        // Update on the edge where the index advances.
        while ((m_edges % DIV) != DIV - 1) step(1'b0, 1'b0, cur, "align");
        cur = 16'h9876;
        step(1'b1, 1'b0, cur, "upd_at_adv");
        repeat (6) step(1'b0, 1'b0, cur, "after_adv");

        // Asynchronous reset while digit 2 is displayed.
        guard = 0;
        do begin
            step(1'b0, 1'b0, cur, "seek_d2");
            guard++;
        end while (last_idx != 2 && guard < 20);
        total++;
        assert (guard < 20) else begin
            bad++;
            $error("FAIL seek_d2_timeout: cycles=%0d expected below 20", guard);
        end
        #2 reset = 1'b1;
        #1 check("async_reset", 4'b1111, 7'h7F);
        @(posedge clock);
        #1 check("reset_hold2", 4'b1111, 7'h7F);
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b0, cur, "restart_d0");

        // Randomised traffic: digit loads, transparent bursts and blanking.
        for (int k = 0; k < 300; k++) begin
            logic u, b;
            u = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 3) == 0) cur = rand_digits();
            step(u, b, cur, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
